// File: rtl/exe_stage_md_if.sv
// Execute-stage bundle: ds->es issue, es->ms result, data SRAM store port and ds bypass taps.
// The execute stage is the slave. Whoever drives ds and ms is the master.
interface exe_stage_md_if #(
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned NB = DATA_W / 8;

   logic              ms_allowin;
   logic              es_allowin;
   logic              ds_to_es_valid;
   logic [11:0]       ds_alu_op;
   logic [2:0]        ds_md_op;
   logic [1:0]        ds_hilo_rd;
   logic [DATA_W-1:0] ds_src1;
   logic [DATA_W-1:0] ds_src2;
   logic [DATA_W-1:0] ds_rt_value;
   logic              ds_load_op;
   logic              ds_mem_we;
   logic [1:0]        ds_mem_size;
   logic              ds_gr_we;
   logic [4:0]        ds_dest;
   logic [DATA_W-1:0] ds_pc;
   logic              es_flush;
   logic              es_to_ms_valid;
   logic              es_res_from_mem;
   logic              es_gr_we;
   logic [4:0]        es_dest;
   logic [DATA_W-1:0] es_pc;
   logic [DATA_W-1:0] es_result;
   logic              data_sram_en;
   logic [NB-1:0]     data_sram_wen;
   logic [DATA_W-1:0] data_sram_addr;
   logic [DATA_W-1:0] data_sram_wdata;
   logic              es_load_op;
   logic [DATA_W-1:0] es_fwd_result;
   logic [4:0]        ES_dest;
   logic              es_md_busy;

   modport master (
      output ms_allowin, ds_to_es_valid, ds_alu_op, ds_md_op, ds_hilo_rd, ds_src1, ds_src2,
             ds_rt_value, ds_load_op, ds_mem_we, ds_mem_size, ds_gr_we, ds_dest, ds_pc, es_flush,
      input  es_allowin, es_to_ms_valid, es_res_from_mem, es_gr_we, es_dest, es_pc, es_result,
             data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, es_load_op,
             es_fwd_result, ES_dest, es_md_busy
   );

   modport slave (
      input  ms_allowin, ds_to_es_valid, ds_alu_op, ds_md_op, ds_hilo_rd, ds_src1, ds_src2,
             ds_rt_value, ds_load_op, ds_mem_we, ds_mem_size, ds_gr_we, ds_dest, ds_pc, es_flush,
      output es_allowin, es_to_ms_valid, es_res_from_mem, es_gr_we, es_dest, es_pc, es_result,
             data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, es_load_op,
             es_fwd_result, ES_dest, es_md_busy
   );
endinterface

// File: rtl/exe_stage_md.sv
// MIPS execute stage: one-hot ALU, iterative mul/div with HI/LO, byte-lane store generation,
// and the valid/allowin handshake, which stalls while a mul/div is in flight.
module exe_stage_md #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MUL_CYCLES = 2
) (
   input logic           clk,
   input logic           reset,
   exe_stage_md_if.slave bus
);
   localparam int unsigned NB         = DATA_W / 8;
   localparam int unsigned OFF_W      = $clog2(NB);
   localparam int unsigned SH_W       = $clog2(DATA_W);
   // One restoring step per quotient bit plus one sign-fix cycle.
   localparam int unsigned DIV_CYCLES = DATA_W + 1;
   localparam int unsigned CNT_W      = $clog2(DIV_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

   typedef struct packed {
      logic [11:0]       alu_op;
      logic [2:0]        md_op;
      logic [1:0]        hilo_rd;
      logic [DATA_W-1:0] src1;
      logic [DATA_W-1:0] src2;
      logic [DATA_W-1:0] rt_value;
      logic              load_op;
      logic              mem_we;
      logic [1:0]        mem_size;
      logic              gr_we;
      logic [4:0]        dest;
      logic [DATA_W-1:0] pc;
   } payload_t;

   payload_t          pl_q, pl_d;
   logic              es_valid_q, es_valid_d;
   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] md_hi_q, md_hi_d, md_lo_q, md_lo_d;
   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

   logic              es_is_md, is_mul, is_sdiv, es_ready_go, es_allowin, handshake, capture;
   logic              ds_is_md, sub_en, slt, sltu;
   logic [SH_W-1:0]   sh;
   logic [31:0]       lui32;
   logic [DATA_W-1:0] addsub, alu_res, ds_mag1, dvsr;
   logic [2*DATA_W-1:0] ext1, ext2, prod;
   logic [DATA_W:0]   trial, diff;
   logic [OFF_W-1:0]  off;
   logic [7:0]        lane_base;
   logic [2:0]        low_mask;
   logic              st_illegal;
   logic [DATA_W-1:0] wdata;

   always_comb begin
      es_is_md    = pl_q.md_op inside {[3'd1:3'd4]};
      is_mul      = pl_q.md_op inside {3'd1, 3'd2};
      is_sdiv     = pl_q.md_op == 3'd3;
      es_ready_go = !es_is_md || (state_q == StDone);
      es_allowin  = !es_valid_q || (es_ready_go && bus.ms_allowin);
      handshake   = es_valid_q && es_ready_go && bus.ms_allowin && !bus.es_flush;
      capture     = bus.ds_to_es_valid && es_allowin;
      ds_is_md    = bus.ds_md_op inside {[3'd1:3'd4]};
   end

   // ALU
   always_comb begin
      sh     = pl_q.src1[SH_W-1:0];
      sub_en = pl_q.alu_op[1] | pl_q.alu_op[2] | pl_q.alu_op[3];
      addsub = pl_q.src1 + (sub_en ? ~pl_q.src2 : pl_q.src2) + {{(DATA_W-1){1'b0}}, sub_en};
      slt    = $signed(pl_q.src1) < $signed(pl_q.src2);
      sltu   = pl_q.src1 < pl_q.src2;
      lui32  = {pl_q.src2[15:0], 16'h0000};
      alu_res = ({DATA_W{pl_q.alu_op[0] | pl_q.alu_op[1]}} & addsub)
              | ({DATA_W{pl_q.alu_op[2]}}  & DATA_W'(slt))
              | ({DATA_W{pl_q.alu_op[3]}}  & DATA_W'(sltu))
              | ({DATA_W{pl_q.alu_op[4]}}  & (pl_q.src1 & pl_q.src2))
              | ({DATA_W{pl_q.alu_op[5]}}  & ~(pl_q.src1 | pl_q.src2))
              | ({DATA_W{pl_q.alu_op[6]}}  & (pl_q.src1 | pl_q.src2))
              | ({DATA_W{pl_q.alu_op[7]}}  & (pl_q.src1 ^ pl_q.src2))
              | ({DATA_W{pl_q.alu_op[8]}}  & (pl_q.src2 << sh))
              | ({DATA_W{pl_q.alu_op[9]}}  & (pl_q.src2 >> sh))
              | ({DATA_W{pl_q.alu_op[10]}} & DATA_W'($signed(pl_q.src2) >>> sh))
              | ({DATA_W{pl_q.alu_op[11]}} & DATA_W'($signed(lui32)));
   end

   // Mul/div datapath and FSM
   always_comb begin
      ext1    = {{DATA_W{pl_q.md_op == 3'd1 && pl_q.src1[DATA_W-1]}}, pl_q.src1};
      ext2    = {{DATA_W{pl_q.md_op == 3'd1 && pl_q.src2[DATA_W-1]}}, pl_q.src2};
      prod    = ext1 * ext2;
      ds_mag1 = (bus.ds_md_op == 3'd3 && bus.ds_src1[DATA_W-1]) ? -bus.ds_src1 : bus.ds_src1;
      dvsr    = (is_sdiv && pl_q.src2[DATA_W-1]) ? -pl_q.src2 : pl_q.src2;
      trial   = {md_hi_q, md_lo_q[DATA_W-1]};
      diff    = trial - {1'b0, dvsr};

      state_d = state_q;
      cnt_d   = cnt_q;
      md_hi_d = md_hi_q;
      md_lo_d = md_lo_q;
      if (bus.es_flush) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (capture && ds_is_md) begin
         state_d = StBusy;
         cnt_d   = '0;
         md_hi_d = '0;
         md_lo_d = ds_mag1;
      end else begin
         unique case (state_q)
            StIdle: ;
            StBusy: begin
               cnt_d = cnt_q + 1'b1;
               if (is_mul) begin
                  if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                     state_d            = StDone;
                     {md_hi_d, md_lo_d} = prod;
                  end
               end else if (cnt_q < CNT_W'(DATA_W)) begin
                  md_hi_d = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
                  md_lo_d = {md_lo_q[DATA_W-2:0], ~diff[DATA_W]};
               end else begin
                  state_d = StDone;
                  if (pl_q.src2 == '0) begin
                     md_lo_d = '1;
                     md_hi_d = pl_q.src1;
                  end else begin
                     md_lo_d = (is_sdiv && (pl_q.src1[DATA_W-1] ^ pl_q.src2[DATA_W-1]))
                               ? -md_lo_q : md_lo_q;
                     md_hi_d = (is_sdiv && pl_q.src1[DATA_W-1]) ? -md_hi_q : md_hi_q;
                  end
               end
            end
            StDone: if (handshake) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Architectural HI/LO, valid and payload
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (handshake) begin
         if (es_is_md) begin
            hi_d = md_hi_q;
            lo_d = md_lo_q;
         end else if (pl_q.md_op == 3'd5) begin
            hi_d = pl_q.src1;
         end else if (pl_q.md_op == 3'd6) begin
            lo_d = pl_q.src1;
         end
      end
      es_valid_d = bus.es_flush ? 1'b0 : (es_allowin ? bus.ds_to_es_valid : es_valid_q);
      pl_d = pl_q;
      if (capture) begin
         pl_d = '{alu_op: bus.ds_alu_op, md_op: bus.ds_md_op, hilo_rd: bus.ds_hilo_rd,
                  src1: bus.ds_src1, src2: bus.ds_src2, rt_value: bus.ds_rt_value,
                  load_op: bus.ds_load_op, mem_we: bus.ds_mem_we, mem_size: bus.ds_mem_size,
                  gr_we: bus.ds_gr_we, dest: bus.ds_dest, pc: bus.ds_pc};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pl_q       <= '0;
         es_valid_q <= 1'b0;
         state_q    <= StIdle;
         cnt_q      <= '0;
         md_hi_q    <= '0;
         md_lo_q    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         pl_q       <= pl_d;
         es_valid_q <= es_valid_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         md_hi_q    <= md_hi_d;
         md_lo_q    <= md_lo_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   // Store lanes: misaligned or oversize stores write nothing.
   always_comb begin
      off = alu_res[OFF_W-1:0];
      unique case (pl_q.mem_size)
         2'd0:    begin lane_base = 8'h01; low_mask = 3'd0; wdata = {NB{pl_q.rt_value[7:0]}}; end
         2'd1:    begin lane_base = 8'h03; low_mask = 3'd1;
                        wdata = {(NB/2){pl_q.rt_value[15:0]}}; end
         2'd2:    begin lane_base = 8'h0F; low_mask = 3'd3;
                        wdata = {(NB/4){pl_q.rt_value[31:0]}}; end
         default: begin lane_base = 8'hFF; low_mask = 3'd7; wdata = pl_q.rt_value; end
      endcase
      st_illegal = (|(off & OFF_W'(low_mask))) || (pl_q.mem_size == 2'd3 && NB < 8);
   end

   assign bus.data_sram_wen = (es_valid_q && pl_q.mem_we && !bus.es_flush && !st_illegal)
                              ? (NB'(lane_base) << off) : '0;
   assign bus.data_sram_wdata = wdata;
   assign bus.data_sram_en    = 1'b1;
   assign bus.data_sram_addr  = alu_res;
   assign bus.es_result       = (pl_q.hilo_rd == 2'b10) ? hi_q :
                                (pl_q.hilo_rd == 2'b01) ? lo_q : alu_res;
   assign bus.es_fwd_result   = bus.es_result;
   assign bus.es_allowin      = es_allowin;
   assign bus.es_to_ms_valid  = es_valid_q && es_ready_go;
   assign bus.es_res_from_mem = pl_q.load_op;
   assign bus.es_gr_we        = pl_q.gr_we;
   assign bus.es_dest         = pl_q.dest;
   assign bus.es_pc           = pl_q.pc;
   assign bus.es_load_op      = es_valid_q && pl_q.load_op;
   assign bus.ES_dest         = pl_q.dest & {5{es_valid_q}};
   assign bus.es_md_busy      = state_q != StIdle;
endmodule

// File: tb/tb_exe_stage_md.sv
// Bench for exe_stage_md (DATA_W=32, MUL_CYCLES=2): a table of ALU/store vectors plus
// mul/div sequences; expected results are queued on issue and checked as ms accepts them.
module tb_exe_stage_md;
   typedef struct {
      logic [11:0] alu_op;
      logic [2:0]  md_op;
      logic [1:0]  hilo;
      logic [31:0] s1, s2, rt;
      logic        we;
      logic [1:0]  size;
      logic [31:0] res;
      logic [3:0]  wen;
      logic [31:0] wdata;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  wen;
      logic [31:0] wdata;
      logic        chk_wdata;
      logic [4:0]  dest;
   } exp_t;

   localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002, OP_SLT = 12'h004,
                           OP_SLTU = 12'h008, OP_AND = 12'h010, OP_NOR = 12'h020,
                           OP_OR = 12'h040, OP_XOR = 12'h080, OP_SLL = 12'h100,
                           OP_SRL = 12'h200, OP_SRA = 12'h400, OP_LUI = 12'h800;

   logic clk = 1'b0;
   logic reset;
   exe_stage_md_if #(.DATA_W(32)) bus ();

   exe_stage_md #(.DATA_W(32), .MUL_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [4:0] dest_ctr = 5'd1;
   vec_t tbl[$];
   int   nb;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [11:0] a, input logic [2:0] m, input logic [1:0] h,
                               input logic [31:0] s1, input logic [31:0] s2,
                               input logic [31:0] rt, input logic we, input logic [1:0] sz,
                               input logic [31:0] res, input logic [3:0] wen,
                               input logic [31:0] wd);
      vec_t v;
      v = '{alu_op: a, md_op: m, hilo: h, s1: s1, s2: s2, rt: rt, we: we, size: sz,
            res: res, wen: wen, wdata: wd};
      return v;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the capturing edge.
   task automatic issue(input vec_t v);
      exp_t e;
      bit   acc = 0;
      bus.ds_alu_op   = v.alu_op;
      bus.ds_md_op    = v.md_op;
      bus.ds_hilo_rd  = v.hilo;
      bus.ds_src1     = v.s1;
      bus.ds_src2     = v.s2;
      bus.ds_rt_value = v.rt;
      bus.ds_mem_we   = v.we;
      bus.ds_mem_size = v.size;
      bus.ds_gr_we    = 1'b1;
      bus.ds_dest     = dest_ctr;
      bus.ds_pc       = 32'hBFC0_0000 + {27'd0, dest_ctr};
      bus.ds_to_es_valid = 1'b1;
      e = '{res: v.res, wen: v.wen, wdata: v.wdata, chk_wdata: v.we, dest: dest_ctr};
      for (int k = 0; k < 200 && !acc; k++) begin
         @(negedge clk);
         if (bus.es_allowin) begin
            sb.push_back(e);
            acc = 1;
         end
         @(posedge clk);
         #1;
      end
      bus.ds_to_es_valid = 1'b0;
      dest_ctr = dest_ctr + 5'd1;
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL issue_timeout: es_allowin never rose for dest %0d", e.dest);
      end
   endtask

   // Counts cycles with es_to_ms_valid low; returns at posedge+1 after it is seen high.
   task automatic wait_done(output int n);
      bit seen = 0;
      n = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (bus.es_to_ms_valid) seen = 1;
         else n++;
         @(posedge clk);
         #1;
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL md_timeout: es_to_ms_valid still low after %0d cycles", n);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus.es_to_ms_valid && bus.ms_allowin && !bus.es_flush) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: result %h with empty scoreboard", bus.es_result);
         end else begin
            mon_e = sb.pop_front();
            chk("result", {32'd0, bus.es_result}, {32'd0, mon_e.res});
            chk("fwd_result", {32'd0, bus.es_fwd_result}, {32'd0, mon_e.res});
            chk("wen", {60'd0, bus.data_sram_wen}, {60'd0, mon_e.wen});
            if (mon_e.chk_wdata)
               chk("wdata", {32'd0, bus.data_sram_wdata}, {32'd0, mon_e.wdata});
            chk("es_dest", {59'd0, bus.es_dest}, {59'd0, mon_e.dest});
            chk("ES_dest", {59'd0, bus.ES_dest}, {59'd0, mon_e.dest});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.ms_allowin = 1'b1;
      bus.es_flush = 1'b0;
      bus.ds_to_es_valid = 1'b0;
      bus.ds_alu_op = '0;
      bus.ds_md_op = '0;
      bus.ds_hilo_rd = '0;
      bus.ds_src1 = '0;
      bus.ds_src2 = '0;
      bus.ds_rt_value = '0;
      bus.ds_load_op = 1'b0;
      bus.ds_mem_we = 1'b0;
      bus.ds_mem_size = '0;
      bus.ds_gr_we = 1'b0;
      bus.ds_dest = '0;
      bus.ds_pc = '0;

      tbl.push_back(mk(OP_SUB, 0, 0, 5, 7, 0, 0, 0, 32'hFFFF_FFFE, 0, 0));
      tbl.push_back(mk(OP_SLT, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(OP_SLTU, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(OP_AND, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 0, 32'hF000_F000, 0, 0));
      tbl.push_back(mk(OP_NOR, 0, 0, 32'hF0F0_F0F0, 32'h0F0F_0F00, 0, 0, 0, 32'h0000_000F, 0, 0));
      tbl.push_back(mk(OP_OR, 0, 0, 32'h1200, 32'h0034, 0, 0, 0, 32'h1234, 0, 0));
      tbl.push_back(mk(OP_XOR, 0, 0, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0, 0, 32'hF0F0_0F0F, 0, 0));
      tbl.push_back(mk(OP_SLL, 0, 0, 4, 1, 0, 0, 0, 32'h10, 0, 0));
      tbl.push_back(mk(OP_SRL, 0, 0, 4, 32'h8000_0000, 0, 0, 0, 32'h0800_0000, 0, 0));
      tbl.push_back(mk(OP_SRA, 0, 0, 4, 32'h8000_0000, 0, 0, 0, 32'hF800_0000, 0, 0));
      tbl.push_back(mk(OP_LUI, 0, 0, 0, 32'h1234, 0, 0, 0, 32'h1234_0000, 0, 0));
      // stores: sb, misaligned sh, aligned sh, sw, misaligned sw, sd on 32-bit, sb lane 1
      tbl.push_back(mk(OP_ADD, 0, 0, 32'h1000, 3, 32'hAB, 1, 0, 32'h1003, 4'b1000, 32'hABAB_ABAB));
      tbl.push_back(mk(OP_ADD, 0, 0, 32'h1000, 1, 32'hBEEF, 1, 1, 32'h1001, 4'b0000,
                       32'hBEEF_BEEF));
      tbl.push_back(mk(OP_ADD, 0, 0, 32'h1000, 2, 32'hBEEF, 1, 1, 32'h1002, 4'b1100,
                       32'hBEEF_BEEF));
      tbl.push_back(mk(OP_ADD, 0, 0, 32'h1000, 0, 32'h1234_5678, 1, 2, 32'h1000, 4'b1111,
                       32'h1234_5678));
      tbl.push_back(mk(OP_ADD, 0, 0, 32'h1000, 2, 32'h1234_5678, 1, 2, 32'h1002, 4'b0000,
                       32'h1234_5678));
      tbl.push_back(mk(OP_ADD, 0, 0, 32'h1000, 0, 32'hCAFE_F00D, 1, 3, 32'h1000, 4'b0000,
                       32'hCAFE_F00D));
      tbl.push_back(mk(OP_ADD, 0, 0, 32'h1000, 1, 32'h5A, 1, 0, 32'h1001, 4'b0010, 32'h5A5A_5A5A));

      repeat (2) @(negedge clk);
      chk("rst_to_ms_valid", {63'd0, bus.es_to_ms_valid}, 64'd0);
      chk("rst_allowin", {63'd0, bus.es_allowin}, 64'd1);
      chk("rst_wen", {60'd0, bus.data_sram_wen}, 64'd0);
      chk("rst_ES_dest", {59'd0, bus.ES_dest}, 64'd0);
      chk("rst_md_busy", {63'd0, bus.es_md_busy}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // addu: valid with result one cycle after capture
      issue(mk(OP_ADD, 0, 0, 5, 7, 0, 0, 0, 12, 0, 0));
      @(negedge clk);
      chk("addu_valid", {63'd0, bus.es_to_ms_valid}, 64'd1);
      chk("addu_result", {32'd0, bus.es_result}, 64'd12);
      @(posedge clk);
      #1;

      foreach (tbl[i]) issue(tbl[i]);

      // multu all-ones
      issue(mk(0, 3'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
      wait_done(nb);
      chk("multu_busy_cycles", nb, 2);
      issue(mk(0, 0, 2'b10, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 0, 0));
      issue(mk(0, 0, 2'b01, 0, 0, 0, 0, 0, 32'h0000_0001, 0, 0));

      // mult 3 * -2
      issue(mk(0, 3'd1, 0, 3, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0));
      wait_done(nb);
      issue(mk(0, 0, 2'b10, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0));
      issue(mk(0, 0, 2'b01, 0, 0, 0, 0, 0, 32'hFFFF_FFFA, 0, 0));

      // div -7 / 2
      issue(mk(0, 3'd3, 0, 32'hFFFF_FFF9, 2, 0, 0, 0, 0, 0, 0));
      wait_done(nb);
      chk("div_busy_cycles", nb, 33);
      issue(mk(0, 0, 2'b01, 0, 0, 0, 0, 0, 32'hFFFF_FFFD, 0, 0));
      issue(mk(0, 0, 2'b10, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0));

      // INT_MIN / -1
      issue(mk(0, 3'd3, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
      wait_done(nb);
      issue(mk(0, 0, 2'b01, 0, 0, 0, 0, 0, 32'h8000_0000, 0, 0));
      issue(mk(0, 0, 2'b10, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0));

      // divu 9 / 0 held in DONE by ms
      issue(mk(0, 3'd4, 0, 9, 0, 0, 0, 0, 0, 0, 0));
      bus.ms_allowin = 1'b0;
      wait_done(nb);
      chk("divu0_busy_cycles", nb, 33);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hold_valid", {63'd0, bus.es_to_ms_valid}, 64'd1);
         chk("hold_allowin", {63'd0, bus.es_allowin}, 64'd0);
         chk("hold_busy", {63'd0, bus.es_md_busy}, 64'd1);
         @(posedge clk);
         #1;
      end
      bus.ms_allowin = 1'b1;
      issue(mk(0, 0, 2'b10, 0, 0, 0, 0, 0, 32'h0000_0009, 0, 0));
      issue(mk(0, 0, 2'b01, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0));

      // div flushed at busy cycle 10: HI/LO keep divu results
      issue(mk(0, 3'd3, 0, 100, 7, 0, 0, 0, 0, 0, 0));
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("flush_pre_busy", {63'd0, bus.es_md_busy}, 64'd1);
      @(posedge clk);
      #1;
      bus.es_flush = 1'b1;
      void'(sb.pop_back());
      @(posedge clk);
      #1;
      bus.es_flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", {63'd0, bus.es_md_busy}, 64'd0);
      chk("flush_valid", {63'd0, bus.es_to_ms_valid}, 64'd0);
      chk("flush_ES_dest", {59'd0, bus.ES_dest}, 64'd0);
      chk("flush_allowin", {63'd0, bus.es_allowin}, 64'd1);
      @(posedge clk);
      #1;
      issue(mk(0, 0, 2'b10, 0, 0, 0, 0, 0, 32'h0000_0009, 0, 0));
      issue(mk(0, 0, 2'b01, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0));

      // mthi / mtlo
      issue(mk(0, 3'd5, 0, 32'h11, 0, 0, 0, 0, 0, 0, 0));
      issue(mk(0, 3'd6, 0, 32'h22, 0, 0, 0, 0, 0, 0, 0));
      issue(mk(0, 0, 2'b10, 0, 0, 0, 0, 0, 32'h11, 0, 0));
      issue(mk(0, 0, 2'b01, 0, 0, 0, 0, 0, 32'h22, 0, 0));

      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
